// File: rtl/spi_master_byte_pkg.sv
`default_nettype none
// ============================================================================
// spi_master_byte_pkg : shared width, state encoding and mode helpers
// Rev 1.0
// ============================================================================
package spi_master_byte_pkg;

  localparam int W_SPI = 8;
  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    SPI_IDLE     = 3'd0,
    SPI_CS_SETUP = 3'd1,
    SPI_XFER     = 3'd2,
    SPI_CS_HOLD  = 3'd3,
    SPI_DONE     = 3'd4
  } spi_state_e;

  localparam logic [1:0] SPI_MODE_0 = 2'd0;
  localparam logic [1:0] SPI_MODE_1 = 2'd1;
  localparam logic [1:0] SPI_MODE_2 = 2'd2;
  localparam logic [1:0] SPI_MODE_3 = 2'd3;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_edge_gen.sv
`default_nettype none
// ============================================================================
// spi_edge_gen : half-bit divider and SCLK edge counter for spi_master_byte
// Rev 1.0
// ============================================================================
module spi_edge_gen
  import spi_master_byte_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int N_EDGES           = 2 * W_SPI
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic half_tick,
  output logic leading,
  output logic trailing,
  output logic last_edge
);

  localparam int                EDGE_W    = $clog2(N_EDGES);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(N_EDGES - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;

  // clear wins over a coincident tick: every state change lands on a tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else if (clear) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else if (enable) begin
      if (half_tick) begin
        div_cnt  <= '0;
        edge_cnt <= edge_cnt + 1'b1;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end
    end
  end

  assign half_tick = enable && (div_cnt == DIV_LAST);
  assign leading   = half_tick && !edge_cnt[0];
  assign trailing  = half_tick &&  edge_cnt[0];
  assign last_edge = half_tick && (edge_cnt == EDGE_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_master_byte.sv
`default_nettype none
// ============================================================================
// spi_master_byte : pin-level SPI master, one byte out and one byte in per request
// Rev 1.0
// ============================================================================
module spi_master_byte
  import spi_master_byte_pkg::*;
#(
  parameter int         CLKS_PER_HALF_BIT = 2,
  parameter logic [1:0] SPI_MODE          = SPI_MODE_0,
  parameter int         W_SPI             = spi_master_byte_pkg::W_SPI
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_dv,
  input  logic [W_SPI-1:0] tx_byte,
  output logic             tx_ready,
  output logic             rx_dv,
  output logic [W_SPI-1:0] rx_byte,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_n
);

  localparam logic CPOL = mode_cpol(SPI_MODE);
  localparam logic CPHA = mode_cpha(SPI_MODE);

  spi_state_e       state;
  spi_state_e       next_state;
  logic [W_SPI-1:0] tx_shift;
  logic [W_SPI-1:0] rx_shift;
  logic             half_tick;
  logic             leading;
  logic             trailing;
  logic             last_edge;
  logic             in_frame;
  logic             in_frame_next;
  logic             in_xfer;
  logic             accept;
  logic             sample_edge;
  logic             shift_edge;

  assign in_frame      = state inside {SPI_CS_SETUP, SPI_XFER, SPI_CS_HOLD};
  assign in_frame_next = next_state inside {SPI_CS_SETUP, SPI_XFER, SPI_CS_HOLD};
  assign in_xfer       = (state == SPI_XFER);
  assign tx_ready      = (state == SPI_IDLE);
  assign accept        = tx_ready && tx_dv;
  assign sample_edge   = in_xfer && (CPHA ? trailing : leading);
  assign shift_edge    = in_xfer && (CPHA ? leading : (trailing && !last_edge));

  spi_edge_gen #(
    .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT),
    .N_EDGES           (2 * W_SPI)
  ) u_edge_gen (
    .clk       (clk),
    .rst       (rst),
    .enable    (in_frame),
    .clear     (next_state != state),
    .half_tick (half_tick),
    .leading   (leading),
    .trailing  (trailing),
    .last_edge (last_edge)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SPI_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      SPI_IDLE:     if (tx_dv)     next_state = SPI_CS_SETUP;
      SPI_CS_SETUP: if (half_tick) next_state = SPI_XFER;
      SPI_XFER:     if (last_edge) next_state = SPI_CS_HOLD;
      SPI_CS_HOLD:  if (half_tick) next_state = SPI_DONE;
      SPI_DONE:                    next_state = SPI_IDLE;
      default:                     next_state = SPI_IDLE;
    endcase
  end

  // Pins are registered from next_state so they change on the same edge as the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_dv    <= 1'b0;
      spi_sclk <= CPOL;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      spi_cs_n <= !in_frame_next;
      rx_dv    <= (next_state == SPI_DONE);
      if (next_state == SPI_DONE) begin
        rx_byte <= rx_shift;
      end

      if (in_xfer && half_tick) begin
        spi_sclk <= ~spi_sclk;
      end else if (!in_xfer) begin
        spi_sclk <= CPOL;
      end

      if (accept) begin
        tx_shift <= tx_byte;
        rx_shift <= '0;
        if (!CPHA) begin
          spi_mosi <= tx_byte[W_SPI-1];
        end
      end else if (shift_edge) begin
        // CPHA=0 already presented the MSB before the first edge
        spi_mosi <= CPHA ? tx_shift[W_SPI-1] : tx_shift[W_SPI-2];
        tx_shift <= tx_shift << 1;
      end

      if (sample_edge) begin
        rx_shift <= {rx_shift[W_SPI-2:0], spi_miso};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_byte.sv
`default_nettype none
// ============================================================================
// tb_spi_master_byte : mode 0 and mode 3 masters against behavioural SPI slaves
// Rev 1.0
// ============================================================================
module tb_spi_master_byte;

  localparam int N      = 2;
  localparam int LAT    = 1 + N * 18;
  localparam int CS_LOW = 18 * N;
  localparam int B2B    = 2 + 18 * N;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       tx_dv    = 1'b0;
  logic [7:0] tx_byte  = 8'h00;
  logic       loop     = 1'b0;
  logic [7:0] slave_tx = 8'h00;

  logic       tx_ready0, rx_dv0, sclk0, mosi0, miso0, cs_n0;
  logic       tx_ready3, rx_dv3, sclk3, mosi3, miso3, cs_n3;
  logic [7:0] rx_byte0, rx_byte3;

  logic       sl0 = 1'b0;
  logic       sl3 = 1'b0;
  logic [7:0] s0_rx = 8'h00;
  logic [7:0] s3_rx = 8'h00;
  int         s0_rise = 0, s0_fall = 0, s3_rise = 0, s3_fall = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign miso0 = loop ? mosi0 : sl0;
  assign miso3 = loop ? mosi3 : sl3;

  spi_master_byte #(.CLKS_PER_HALF_BIT(N), .SPI_MODE(2'd0), .W_SPI(8)) dut0 (
    .clk(clk), .rst(rst), .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_ready(tx_ready0),
    .rx_dv(rx_dv0), .rx_byte(rx_byte0), .spi_sclk(sclk0), .spi_mosi(mosi0),
    .spi_miso(miso0), .spi_cs_n(cs_n0)
  );

  spi_master_byte #(.CLKS_PER_HALF_BIT(N), .SPI_MODE(2'd3), .W_SPI(8)) dut3 (
    .clk(clk), .rst(rst), .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_ready(tx_ready3),
    .rx_dv(rx_dv3), .rx_byte(rx_byte3), .spi_sclk(sclk3), .spi_mosi(mosi3),
    .spi_miso(miso3), .spi_cs_n(cs_n3)
  );

  // Mode 0 slave: data valid before the first rising edge, captured on rising, changed on falling
  always @(negedge cs_n0) begin
    s0_rx = 8'h00; s0_rise = 0; s0_fall = 0; sl0 = slave_tx[7];
  end
  always @(posedge sclk0) if (!cs_n0) begin
    s0_rx = {s0_rx[6:0], mosi0}; s0_rise++;
  end
  always @(negedge sclk0) if (!cs_n0) begin
    s0_fall++;
    if (s0_fall < 8) sl0 = slave_tx[7 - s0_fall];
  end

  // Mode 3 slave: data changed on falling (leading) edge, captured on rising
  always @(negedge cs_n3) begin
    s3_rx = 8'h00; s3_rise = 0; s3_fall = 0;
  end
  always @(negedge sclk3) if (!cs_n3) begin
    if (s3_fall < 8) sl3 = slave_tx[7 - s3_fall];
    s3_fall++;
  end
  always @(posedge sclk3) if (!cs_n3) begin
    s3_rx = {s3_rx[6:0], mosi3}; s3_rise++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sb, input bit lp,
                          input int inj, input string tag);
    int lat0 = 0, lat3 = 0, cs0 = 0, cs3 = 0;
    logic [7:0] got0 = 8'h00, got3 = 8'h00, exp_rx;
    exp_rx = lp ? tx : sb;
    @(negedge clk);
    check({tag, " ready"}, {30'd0, tx_ready0, tx_ready3}, 32'd3);
    loop = lp; slave_tx = sb; tx_byte = tx; tx_dv = 1'b1;
    @(negedge clk);
    tx_dv = 1'b0; tx_byte = ~tx;
    for (int c = 1; c <= LAT + 20; c++) begin
      if (inj != 0 && c == inj) begin tx_dv = 1'b1; tx_byte = 8'h55; end
      else if (inj != 0 && c == inj + 1) tx_dv = 1'b0;
      if (lat0 == 0) begin
        if (rx_dv0) begin lat0 = c; got0 = rx_byte0; end else if (!cs_n0) cs0++;
      end
      if (lat3 == 0) begin
        if (rx_dv3) begin lat3 = c; got3 = rx_byte3; end else if (!cs_n3) cs3++;
      end
      if (lat0 != 0 && lat3 != 0) break;
      @(negedge clk);
    end
    check({tag, " lat0"}, lat0, LAT);
    check({tag, " lat3"}, lat3, LAT);
    check({tag, " cslow0"}, cs0, CS_LOW);
    check({tag, " cslow3"}, cs3, CS_LOW);
    check({tag, " rx0"}, got0, exp_rx);
    check({tag, " rx3"}, got3, exp_rx);
    check({tag, " mosi0"}, s0_rx, tx);
    check({tag, " mosi3"}, s3_rx, tx);
    check({tag, " edges0"}, {s0_rise[15:0], s0_fall[15:0]}, {16'd8, 16'd8});
    check({tag, " edges3"}, {s3_rise[15:0], s3_fall[15:0]}, {16'd8, 16'd8});
    @(negedge clk);
    check({tag, " post dv"}, {30'd0, rx_dv0, rx_dv3}, 32'd0);
    check({tag, " post ready"}, {30'd0, tx_ready0, tx_ready3}, 32'd3);
    check({tag, " idle pins"}, {28'd0, sclk0, sclk3, cs_n0, cs_n3}, 32'b0111);
    check({tag, " hold rx"}, {rx_byte0, rx_byte3}, {exp_rx, exp_rx});
  endtask

  initial begin
    int extra;
    int n_dv0, n_dv3, t1, t2, gap;
    logic [7:0] b1, b2, r;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ready", {30'd0, tx_ready0, tx_ready3}, 32'd3);
    check("reset dv", {30'd0, rx_dv0, rx_dv3}, 32'd0);
    check("reset rx", {rx_byte0, rx_byte3}, 16'h0000);
    check("reset pins", {26'd0, sclk0, sclk3, mosi0, mosi3, cs_n0, cs_n3}, 32'b010011);
    rst = 1'b1;

    run_xfer(8'hA5, 8'h00, 1'b1, 0, "loop_a5");
    run_xfer(8'hFF, 8'h3C, 1'b0, 0, "slave_3c");
    run_xfer(8'h81, 8'h00, 1'b1, 0, "loop_81");

    // A request during a busy transfer is dropped, not queued
    run_xfer(8'hA5, 8'h00, 1'b1, 10, "busy_req");
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      if (rx_dv0 || rx_dv3 || !cs_n0 || !cs_n3) extra++;
      @(negedge clk);
    end
    check("busy no second xfer", extra, 0);

    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom_range(0, 255));
      run_xfer(r, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, "random");
    end

    // Asynchronous abort after the 7th SCLK edge
    @(negedge clk);
    loop = 1'b1; tx_byte = 8'hC3; tx_dv = 1'b1;
    @(negedge clk);
    tx_dv = 1'b0;
    for (int k = 0; k < 200 && (s0_rise + s0_fall) < 7; k++) @(negedge clk);
    check("abort at edge 7", s0_rise + s0_fall, 7);
    #2 rst = 1'b0;
    #1;
    check("abort pins", {28'd0, sclk0, sclk3, cs_n0, cs_n3}, 32'b0111);
    check("abort ready", {30'd0, tx_ready0, tx_ready3}, 32'd3);
    check("abort dv", {30'd0, rx_dv0, rx_dv3}, 32'd0);
    check("abort rx", {rx_byte0, rx_byte3}, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      if (rx_dv0 || rx_dv3) extra++;
      @(negedge clk);
    end
    check("abort no dv", extra, 0);
    run_xfer(8'h12, 8'($urandom_range(0, 255)), 1'b1, 0, "after_abort");

    // Back-to-back with tx_dv held high
    @(negedge clk);
    loop = 1'b1; tx_byte = 8'h01; tx_dv = 1'b1;
    @(negedge clk);
    tx_byte = 8'h02;
    n_dv0 = 0; n_dv3 = 0; t1 = 0; t2 = 0; gap = 0; b1 = 8'h00; b2 = 8'h00;
    for (int c = 1; c <= 120; c++) begin
      if (rx_dv3) n_dv3++;
      if (rx_dv0) begin
        n_dv0++;
        if (n_dv0 == 1) begin t1 = c; b1 = rx_byte0; end
        else if (n_dv0 == 2) begin t2 = c; b2 = rx_byte0; end
      end
      if (t1 != 0 && t2 == 0 && cs_n0) gap++;
      if (t1 != 0 && c == t1 + 2) tx_dv = 1'b0;
      @(negedge clk);
    end
    tx_dv = 1'b0;
    check("b2b count0", n_dv0, 2);
    check("b2b count3", n_dv3, 2);
    check("b2b first lat", t1, LAT);
    check("b2b spacing", t2 - t1, B2B);
    check("b2b bytes", {b1, b2}, 16'h0102);
    check("b2b cs gap", {31'd0, gap >= 1}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master_byte.md
Name: spi_master_byte

Overview:
- Physical SPI master that sits directly downstream of the CPU's SPI control stage.
- Accepts one MOSI byte per request (dv_mosi/data_mosi style), serialises it on SCLK/MOSI under chip-select, and captures 8 MISO bits in the same transfer.
- Returns the captured byte with a one-cycle valid strobe, which the CPU write-back mux consumes as SPI data.
- Replaces the fake SPI loop with a real pin-level engine.

Parameters:
- CLKS_PER_HALF_BIT, 2, clk cycles per SCLK half-period; legal range is 2..255.
- SPI_MODE, 0, SPI mode 0..3. CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
- W_SPI, 8, bits per transfer.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_dv  in  1  transfer request, sampled only while tx_ready=1.
- tx_byte  in  W_SPI  byte to send, MSB first.
- tx_ready  out  1  engine idle and able to accept a request.
- rx_dv  out  1  one-cycle strobe; rx_byte is valid in that cycle.
- rx_byte  out  W_SPI  byte received on MISO.
- spi_sclk  out  1  serial clock.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.
- spi_cs_n  out  1  chip select, active-low.

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, tx_ready=1, rx_dv=0, rx_byte=0, spi_sclk=CPOL, spi_mosi=0, spi_cs_n=1, divider counter=0, edge counter=0.
- Reset asserted mid-transfer aborts immediately. No rx_dv is produced for the aborted byte.
- States and transitions:
  - IDLE -> CS_SETUP when tx_dv=1 && tx_ready=1.
  - CS_SETUP -> XFER after CLKS_PER_HALF_BIT cycles.
  - XFER -> CS_HOLD after 16 SCLK edges.
  - CS_HOLD -> DONE after CLKS_PER_HALF_BIT cycles.
  - DONE -> IDLE after 1 cycle.
- Accept cycle (IDLE with tx_dv=1): tx_byte is latched into the shift register; tx_ready goes 0 on the next edge.
- CS_SETUP: spi_cs_n=0 and sclk held at CPOL.
  - CPHA=0: spi_mosi=bit[W_SPI-1] for the whole state.
  - CPHA=1: spi_mosi holds its previous value.
- XFER: sclk toggles every CLKS_PER_HALF_BIT cycles; an edge counter counts 0..15.
  - Odd-numbered edges (1st, 3rd, …) are leading; even-numbered edges are trailing.
  - CPHA=0: MISO is sampled on leading edges; the next MOSI bit is shifted out on trailing edges. No shift after the last edge.
  - CPHA=1: the MOSI bit is shifted out on leading edges; MISO is sampled on trailing edges.
  - MISO is sampled in the clk cycle the sclk edge is driven (register-level sample, no extra synchroniser).
  - Bits shift into rx_shift LSB-first position, so the first received bit ends at MSB.
- CS_HOLD: sclk=CPOL and spi_cs_n=0.
- DONE: spi_cs_n=1, rx_dv=1 for exactly one cycle, rx_byte=rx_shift. tx_ready=1 from the cycle after DONE.
- Latency from the accept edge to rx_dv: 1 + CLKS_PER_HALF_BIT*(1+16+1) cycles. With the default of 2 this is 37 cycles.
- tx_dv while tx_ready=0 is ignored and not queued. tx_byte changes during a transfer have no effect.
- Back-to-back transfers: a tx_dv held high in the first tx_ready cycle starts the next transfer. spi_cs_n is high for at least 1 cycle between bytes.
- rx_byte holds its value until the next DONE or a reset.
- Divider counter wrap: counts 0..CLKS_PER_HALF_BIT-1 and clears on each state change.

Decomposition:
- Shared package: W_SPI; state encoding SPI_IDLE, SPI_CS_SETUP, SPI_XFER, SPI_CS_HOLD, SPI_DONE (3-bit); SPI mode constants.
- Sub-module spi_edge_gen holds the divider and the edge counter.
  - Outputs: half_tick, leading, trailing, last_edge.
  - Inputs: enable, clear.
- The top level holds the FSM, the shift registers and the pin outputs.

Test Plan:
- Mode 0, MOSI looped to MISO, send 0xA5 -> rx_dv after 37 cycles with rx_byte=0xA5; MOSI sequence 1,0,1,0,0,1,0,1; spi_cs_n low for 36 cycles.
- Mode 0, slave model returns 0x3C while master sends 0xFF -> rx_byte=0x3C; exactly 8 sclk rising edges; idle sclk=0.
- Mode 3 loopback 0x81 -> rx_byte=0x81; sclk idles high; 8 falling-then-rising pairs.
- tx_dv pulsed with 0x55 at cycle 10 of an active 0xA5 transfer -> ignored; a single rx_dv with 0xA5 and no second transfer.
- rst driven low at edge 7 of a transfer -> asynchronously spi_cs_n=1, sclk=CPOL, tx_ready=1, no rx_dv. The next request 0x12 completes normally with loopback 0x12.
- tx_dv held high continuously with 0x01 then 0x02 -> two transfers; spi_cs_n high ≥1 cycle between them; rx_dv strobes 38 cycles apart; rx_byte sequence 0x01, 0x02.
